// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// BCD digit constants and the digit clamp helper.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // A preset nibble above 9 is not a valid BCD digit; saturate it to 9
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain. A decrement of a digit sitting at 0
// wraps it to 9 and raises borrow_out so the next digit up decrements too.
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       not_reset,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       is_zero,
    output logic       borrow_out
);

    assign is_zero    = (q == BCD_ZERO);
    assign borrow_out = dec & is_zero;

    // Digit register: load wins over decrement, decrement wraps 0 -> 9
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= d;
        end else if (dec) begin
            q <= is_zero ? BCD_MAX : (q - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer. Loads a clamped BCD preset, decrements
// once per tick while running, and pulses done when the count reaches zero.
// Optional feature macro: BCD_AUTO_RELOAD_EN (reload the preset on expiry
// and keep running instead of stopping in EXPIRED).
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                not_reset,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] q,
    output logic                running,
    output logic                done
);

    timer_state_t state, state_next;

    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] digit_d;
    logic [DIGITS-1:0]   digit_zero;
    logic [DIGITS-1:0]   borrow;
    logic [DIGITS-1:0]   digit_dec;
    logic                digit_load;
    logic                dec_en;
    logic                count_zero;
    logic                q_is_one;
    logic                done_next;

    assign count_zero = &digit_zero;
    assign q_is_one   = (q == (4*DIGITS)'(1));

    // A decrement happens only in RUN when neither load nor pause outranks the tick
    assign dec_en = (state == RUN) & tick & ~load & ~pause;

    // Saturate every preset nibble to a legal BCD digit
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end
    end

`ifdef BCD_AUTO_RELOAD_EN
    logic [4*DIGITS-1:0] reload_q;
    logic                reload_now;

    // Remember the last clamped preset so an expiry can restart from it
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamped;
        end
    end

    assign reload_now = dec_en & q_is_one & (reload_q != '0);
    assign digit_load = load | reload_now;
    assign digit_d    = load ? load_clamped : reload_q;
`else
    assign digit_load = load;
    assign digit_d    = load_clamped;
`endif

    // Digit 0 takes the tick-driven decrement, higher digits take the borrow below them
    always_comb begin
        digit_dec    = '0;
        digit_dec[0] = dec_en;
        for (int i = 1; i < DIGITS; i++) begin
            digit_dec[i] = borrow[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .not_reset  (not_reset),
                .dec        (digit_dec[g]),
                .load       (digit_load),
                .d          (digit_d[4*g +: 4]),
                .q          (q[4*g +: 4]),
                .is_zero    (digit_zero[g]),
                .borrow_out (borrow[g])
            );
        end
    endgenerate

    // State register plus the registered running and done outputs
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            done    <= done_next;
        end
    end

    // Next-state and done decision in priority order load > pause > start > tick.
    // A borrow out of the top digit would mean an underflow; RUN is only entered
    // with a nonzero count so it cannot happen, but it is treated as expiry too.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (start && !count_zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick && (q_is_one || borrow[DIGITS-1])) begin
                        done_next = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
                        state_next = reload_now ? RUN : EXPIRED;
`else
                        state_next = EXPIRED;
`endif
                    end
                end
                EXPIRED: begin
                    state_next = EXPIRED;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer with DIGITS=2.
// Honors BCD_AUTO_RELOAD_EN the same way the design does.
module tb_bcd_countdown_timer;

    logic       clk;
    logic       not_reset;
    logic       tick;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] q;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clk      (clk),
        .not_reset(not_reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .running  (running),
        .done     (done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal 0..99 to two-digit BCD
    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes, let the edge take them, then drop them again
    task automatic cycle(input logic l, input logic [7:0] lv, input logic s, input logic p, input logic t);
        load     = l;
        load_val = lv;
        start    = s;
        pause    = p;
        tick     = t;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        not_reset = 1'b0;
        tick      = 1'b0;
        load      = 1'b0;
        load_val  = 8'h00;
        start     = 1'b0;
        pause     = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_q", q, 8'h00);
        check("reset_running", {7'd0, running}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        not_reset = 1'b1;

        // Count 12 down to 00
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        check("t1_load_q", q, 8'h12);
        check("t1_load_running", {7'd0, running}, 8'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t1_start_running", {7'd0, running}, 8'd1);
        check("t1_start_q", q, 8'h12);
        for (int n = 11; n >= 1; n--) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check("t1_count_q", q, to_bcd(n));
            check("t1_count_done", {7'd0, done}, 8'd0);
            check("t1_count_running", {7'd0, running}, 8'd1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t1_last_done", {7'd0, done}, 8'd1);
`ifdef BCD_AUTO_RELOAD_EN
        check("t1_last_q_reload", q, 8'h12);
        check("t1_last_running", {7'd0, running}, 8'd1);
`else
        check("t1_last_q", q, 8'h00);
        check("t1_last_running", {7'd0, running}, 8'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t1_after_done", {7'd0, done}, 8'd0);
        check("t1_after_q", q, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t1_expired_start_running", {7'd0, running}, 8'd0);
        check("t1_expired_start_q", q, 8'h00);
`endif

        // Borrow across digits: 20 -> 19
        cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        check("t2_load_running", {7'd0, running}, 8'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t2_borrow_q", q, 8'h19);

        // Pause and resume
        cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t3_two_ticks_q", q, 8'h03);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t3_pause_q", q, 8'h03);
        check("t3_pause_running", {7'd0, running}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check("t3_paused_tick_q", q, 8'h03);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t3_resume_running", {7'd0, running}, 8'd1);
        check("t3_resume_q", q, 8'h03);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t3_resumed_q", q, 8'h02);

        // Clamp and zero-start
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("t4_clamp_low_q", q, 8'h39);
        check("t4_load_stops_running", {7'd0, running}, 8'd0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("t4_clamp_high_q", q, 8'h95);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t4_zero_start_running", {7'd0, running}, 8'd0);
        check("t4_zero_start_q", q, 8'h00);
        check("t4_zero_start_done", {7'd0, done}, 8'd0);

        // Asynchronous reset in the middle of a count
        cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        check("t5_before_reset_q", q, 8'h37);
        #2;
        not_reset = 1'b0;
        #1;
        check("t5_async_q", q, 8'h00);
        check("t5_async_running", {7'd0, running}, 8'd0);
        check("t5_async_done", {7'd0, done}, 8'd0);
        @(posedge clk);
        #1;
        not_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check("t5_post_done", {7'd0, done}, 8'd0);
            check("t5_post_q", q, 8'h00);
        end

`ifdef BCD_AUTO_RELOAD_EN
        // Auto reload: 02 -> 01 -> 02 -> 01 -> 02
        cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check("t6_q", q, (i % 2 == 0) ? 8'h01 : 8'h02);
            check("t6_done", {7'd0, done}, (i % 2 == 0) ? 8'd0 : 8'd1);
            check("t6_running", {7'd0, running}, 8'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
